// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC checker.
package crc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } crc_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Default width of the frame bit counter.
    localparam int unsigned CRC_LEN_W = 16;

endpackage

// File: rtl/crc_lfsr_step.sv
// One MSB-first LFSR step: folds a single message bit into the running CRC.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC8_POLY)
) (
    input  logic [WIDTH-1:0] crc,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc_next
);

    logic fb;

    always_comb begin
        fb       = crc[WIDTH-1] ^ bit_in;
        crc_next = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_serial_checker.sv
// Serial CRC checker: shifts message+CRC bits through an LFSR and issues a
// one-cycle pass/fail verdict after the last bit of each frame.
module crc_serial_checker
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(CRC8_POLY),
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(CRC8_INIT),
    parameter int unsigned      MIN_BITS = WIDTH + 1,
    parameter int unsigned      LEN_W    = CRC_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             last,
    output logic             crc_valid,
    output logic             crc_error,
    output logic             busy,
    output logic [WIDTH-1:0] remainder,
    output logic [LEN_W-1:0] bit_count
);

    localparam logic [LEN_W-1:0] MIN_CNT = LEN_W'(MIN_BITS);

    crc_state_e       state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [WIDTH-1:0] step_base, step_out;
    logic [LEN_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             pass;

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .crc      (step_base),
        .bit_in   (bit_in),
        .crc_next (step_out)
    );

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        count_d   = count_q;
        step_base = crc_q;

        // start wins in every state; a frame in progress is silently dropped.
        if (start) begin
            step_base = INIT;
            crc_d     = INIT;
            count_d   = '0;
            state_d   = StShift;
            if (bit_valid) begin
                crc_d   = step_out;
                count_d = LEN_W'(1);
                if (last) begin
                    state_d = StDone;
                end
            end
        end else begin
            unique case (state_q)
                StShift: begin
                    if (bit_valid) begin
                        crc_d   = step_out;
                        count_d = (count_q == '1) ? count_q : count_q + LEN_W'(1);
                        if (last) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                StIdle:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        // Verdict is computed on the values DONE will hold, so it can be registered.
        pass    = (crc_d == '0) && (count_d >= MIN_CNT);
        valid_d = (state_d == StDone) && pass;
        error_d = (state_d == StDone) && !pass;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            crc_q   <= INIT;
            count_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            count_q <= count_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign crc_valid = valid_q;
    assign crc_error = error_q;
    assign busy      = (state_q == StShift);
    assign remainder = crc_q;
    assign bit_count = count_q;

endmodule

// File: tb/tb_crc_serial_checker.sv
// Self-checking bench for crc_serial_checker using a polynomial long-division model.
module tb_crc_serial_checker;

    localparam int unsigned W    = 8;
    localparam int unsigned MINB = W + 1;
    localparam int unsigned FULL = 32'h107;

    logic        clk = 1'b0;
    logic        rst, start, bit_valid, bit_in, last;
    logic        crc_valid, crc_error, busy;
    logic [7:0]  remainder;
    logic [15:0] bit_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          valid_pulses = 0;
    int          error_pulses = 0;
    logic [4:0]  ds_count = 5'd0;

    crc_serial_checker #(
        .WIDTH    (8),
        .POLY     (8'h07),
        .INIT     (8'h00),
        .MIN_BITS (9),
        .LEN_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .last      (last),
        .crc_valid (crc_valid),
        .crc_error (crc_error),
        .busy      (busy),
        .remainder (remainder),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    // Downstream valid-frame counter plus pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (crc_valid === 1'b1) begin
            valid_pulses++;
            ds_count <= ds_count + 5'd1;
        end
        if (crc_error === 1'b1) error_pulses++;
    end

    // Remainder of bits(x) * x^W divided by the generator, by long division.
    function automatic int unsigned model_rem(input bit bits[$]);
        int unsigned r = 0;
        for (int i = 0; i < bits.size() + W; i++) begin
            r = (r << 1) | ((i < bits.size()) ? 32'(bits[i]) : 32'd0);
            if (r[W]) r = r ^ FULL;
        end
        return r;
    endfunction

    task automatic drive_cycle(input logic s, input logic bv, input logic b, input logic l);
        start     = s;
        bit_valid = bv;
        bit_in    = b;
        last      = l;
        @(posedge clk);
        #1;
        start     = 1'b0;
        bit_valid = 1'b0;
        last      = 1'b0;
    endtask

    task automatic send_frame(input bit bits[$], input bit with_start, input bit start_with_bit,
                              input int max_gap);
        int idx = 0;
        if (with_start) begin
            if (start_with_bit) begin
                drive_cycle(1'b1, 1'b1, bits[0], bits.size() == 1);
                idx = 1;
            end else begin
                drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int i = idx; i < bits.size(); i++) begin
            if (max_gap > 0) begin
                // Idle cycles carry junk on bit_in/last that must be ignored.
                repeat ($urandom_range(max_gap, 0))
                    drive_cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            end
            drive_cycle(1'b0, 1'b1, bits[i], i == bits.size() - 1);
        end
    endtask

    function automatic void push_byte(inout bit q[$], input logic [7:0] v);
        for (int i = 7; i >= 0; i--) q.push_back(v[i]);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (crc_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", crc_valid);
        end
        n_checks++;
        if (crc_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_error: got %b want 0", crc_error);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (remainder !== 8'h00) begin
            n_fail++; $display("FAIL reset_remainder: got %h want 00", remainder);
        end
        n_checks++;
        if (bit_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", bit_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        bit bits[$];
        push_byte(bits, 8'h31);
        push_byte(bits, 8'h97);
        send_frame(bits, 1'b1, 1'b0, 0);
        n_checks++;
        if (crc_valid !== 1'b1 || crc_error !== 1'b0) begin
            n_fail++; $display("FAIL good_verdict: got v=%b e=%b want v=1 e=0", crc_valid, crc_error);
        end
        n_checks++;
        if (remainder !== 8'(model_rem(bits))) begin
            n_fail++; $display("FAIL good_remainder: got %h want %h", remainder, model_rem(bits));
        end
        n_checks++;
        if (bit_count !== 16'd16) begin
            n_fail++; $display("FAIL good_count: got %0d want 16", bit_count);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL good_busy_done: got %b want 0", busy);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (crc_valid !== 1'b0) begin
            n_fail++; $display("FAIL good_pulse_width: got %b want 0", crc_valid);
        end
        n_checks++;
        if (remainder !== 8'h00 || bit_count !== 16'd16) begin
            n_fail++; $display("FAIL good_hold: got %h/%0d want 00/16", remainder, bit_count);
        end
    endtask

    task automatic test_bit_error();
        bit bits[$];
        push_byte(bits, 8'h39);
        push_byte(bits, 8'h97);
        send_frame(bits, 1'b1, 1'b0, 0);
        n_checks++;
        if (crc_error !== 1'b1 || crc_valid !== 1'b0) begin
            n_fail++; $display("FAIL biterr_verdict: got v=%b e=%b want v=0 e=1", crc_valid, crc_error);
        end
        n_checks++;
        if (remainder !== 8'(model_rem(bits)) || remainder === 8'h00) begin
            n_fail++; $display("FAIL biterr_remainder: got %h want %h", remainder, model_rem(bits));
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_short_frame();
        bit bits[$] = '{0, 0, 0, 0};
        send_frame(bits, 1'b1, 1'b0, 0);
        n_checks++;
        if (crc_error !== 1'b1 || crc_valid !== 1'b0) begin
            n_fail++; $display("FAIL short_verdict: got v=%b e=%b want v=0 e=1", crc_valid, crc_error);
        end
        n_checks++;
        if (remainder !== 8'h00 || bit_count !== 16'd4) begin
            n_fail++; $display("FAIL short_state: got %h/%0d want 00/4", remainder, bit_count);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit         f1[$];
        bit         f2[$];
        logic [4:0] ds0;
        int unsigned c;
        push_byte(f1, 8'h31);
        push_byte(f1, 8'h97);
        for (int i = 0; i < 3; i++) push_byte(f2, 8'($urandom));
        c = model_rem(f2);
        push_byte(f2, c[7:0]);
        ds0 = ds_count;
        send_frame(f1, 1'b1, 1'b0, 0);
        n_checks++;
        if (crc_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_valid: got %b want 1", crc_valid);
        end
        // start lands in DONE
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || crc_valid !== 1'b0 || bit_count !== 16'd0) begin
            n_fail++; $display("FAIL b2b_restart: got busy=%b v=%b cnt=%0d want 1/0/0",
                               busy, crc_valid, bit_count);
        end
        send_frame(f2, 1'b0, 1'b0, 3);
        n_checks++;
        if (crc_valid !== 1'b1 || bit_count !== 16'd32) begin
            n_fail++; $display("FAIL b2b_second: got v=%b cnt=%0d want 1/32", crc_valid, bit_count);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ds_count !== 5'(ds0 + 5'd2)) begin
            n_fail++; $display("FAIL b2b_counter: got %0d want %0d", ds_count, 5'(ds0 + 5'd2));
        end
    endtask

    task automatic test_abort_reset();
        int v0 = valid_pulses;
        int e0 = error_pulses;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1, 1'($urandom), 1'b0);
        n_checks++;
        if (busy !== 1'b1 || bit_count !== 16'd7) begin
            n_fail++; $display("FAIL abort_mid: got busy=%b cnt=%0d want 1/7", busy, bit_count);
        end
        rst = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || remainder !== 8'h00 || bit_count !== 16'd0) begin
            n_fail++; $display("FAIL abort_rst_state: got busy=%b rem=%h cnt=%0d want 0/00/0",
                               busy, remainder, bit_count);
        end
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (valid_pulses != v0 || error_pulses != e0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_rst_pulse: got %0d/%0d busy=%b want %0d/%0d busy=0",
                               valid_pulses - v0, error_pulses - e0, busy, 0, 0);
        end
    endtask

    task automatic test_abort_restart();
        bit bits[$];
        int unsigned c;
        int v0 = valid_pulses;
        int e0 = error_pulses;
        push_byte(bits, 8'($urandom));
        push_byte(bits, 8'($urandom));
        c = model_rem(bits);
        push_byte(bits, c[7:0]);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1, 1'($urandom), 1'b0);
        send_frame(bits, 1'b1, 1'b1, 2);
        n_checks++;
        if (crc_valid !== 1'b1 || bit_count !== 16'd24) begin
            n_fail++; $display("FAIL restart_verdict: got v=%b cnt=%0d want 1/24", crc_valid, bit_count);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (valid_pulses - v0 != 1 || error_pulses != e0) begin
            n_fail++; $display("FAIL restart_pulses: got v=%0d e=%0d want 1/0",
                               valid_pulses - v0, error_pulses - e0);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 24; f++) begin
            bit          bits[$];
            int unsigned c, rem;
            bit          exp_valid;
            int          n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) bits.push_back(1'($urandom));
            if ($urandom_range(3, 0) != 0) begin
                c = model_rem(bits);
                push_byte(bits, c[7:0]);
            end
            if ($urandom_range(3, 0) == 0) begin
                int k = $urandom_range(bits.size() - 1, 0);
                bits[k] = ~bits[k];
            end
            rem       = model_rem(bits);
            exp_valid = (rem == 0) && (bits.size() >= MINB);
            send_frame(bits, 1'b1, 1'($urandom), $urandom_range(2, 0));
            n_checks++;
            if (crc_valid !== exp_valid || crc_error !== !exp_valid) begin
                n_fail++; $display("FAIL rand_verdict[%0d]: got v=%b e=%b want v=%b e=%b",
                                   f, crc_valid, crc_error, exp_valid, !exp_valid);
            end
            n_checks++;
            if (remainder !== 8'(rem) || bit_count !== 16'(bits.size())) begin
                n_fail++; $display("FAIL rand_state[%0d]: got %h/%0d want %h/%0d",
                                   f, remainder, bit_count, rem, bits.size());
            end
            if ($urandom_range(1, 0) == 1) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        last      = 1'b0;
        test_reset();
        test_good_frame();
        test_bit_error();
        test_short_frame();
        test_back_to_back();
        test_abort_reset();
        test_abort_restart();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_serial_checker.md
# crc_serial_checker

Serial CRC checker that sits directly upstream of the 5-bit valid-frame counter. It shifts an MSB-first bit stream (message bits followed by the transmitted CRC bits) through a parameterised LFSR. At end of frame it emits a one-cycle `crc_valid` pulse when the remainder is zero, or a `crc_error` pulse otherwise. The downstream counter increments on `crc_valid`.

## Interface
- `WIDTH`, 8: CRC width in bits (range 4..32).
- `POLY`, 8'h07: generator polynomial, implicit x^WIDTH term omitted.
- `INIT`, 0: LFSR preset value loaded at frame start.
- `MIN_BITS`, WIDTH+1: shortest legal frame length, message plus CRC.
- `LEN_W`, 16: width of the frame bit counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle strobe that begins a frame.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_in`  in  1  serial data, MSB first.
- `last`  in  1  qualifies `bit_in` as the final bit of the frame; ignored unless `bit_valid` is high.
- `crc_valid`  out  1  one-cycle pulse: frame passed.
- `crc_error`  out  1  one-cycle pulse: frame failed (nonzero remainder or too short).
- `busy`  out  1  high while a frame is in progress (state SHIFT).
- `remainder`  out  WIDTH  current LFSR contents.
- `bit_count`  out  LEN_W  bits accepted in the current or most recent frame; saturates at all-ones.

## Operation
- **LFSR step.** `fb = crc[WIDTH-1] ^ bit_in`; `crc_next = {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)`.
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE**
  - `bit_valid` and `last` are ignored.
  - On `start`: crc <= INIT, bit_count <= 0, go to SHIFT.
- **start with `bit_valid` in the same cycle:** that bit is the first bit of the frame. crc <= step(INIT, bit_in), bit_count <= 1. If `last` is also high, go straight to DONE.
- **SHIFT**
  - Each `bit_valid` cycle: crc <= crc_next, bit_count++ (saturating).
  - `bit_valid && last`: go to DONE.
  - `start` in SHIFT aborts the current frame and restarts it (same loading as IDLE). The aborted frame produces no pulse.
- **DONE** lasts exactly one cycle, then returns to IDLE.
  - `crc_valid` = (remainder == 0) && (bit_count >= MIN_BITS).
  - `crc_error` = the inverse of that condition.
  - Exactly one of `crc_valid` / `crc_error` is high in DONE.
  - `start` in DONE is accepted as in IDLE: the next state is SHIFT, and the DONE pulse is still emitted that cycle.
- **Between frames:** `remainder` and `bit_count` hold their values until the next `start`.
- **Reset** (any state, including mid-frame):
  - state = IDLE, crc = INIT, bit_count = 0.
  - crc_valid = 0, crc_error = 0, busy = 0.
  - No pulse for the interrupted frame.

## Timing
- All outputs are registered, and none depends combinationally on an input.
- The pulse appears the cycle after the edge that samples the last bit, so latency from last bit to verdict is 1 cycle.
- Back-to-back frames are allowed with zero gap: a `start` one cycle after `last` lands in DONE.
- `busy` rises the cycle after `start` and falls in the cycle of DONE.
- Gaps in `bit_valid` inside a frame are allowed and hold all state.

## Structure
- **Shared package `crc_pkg`:**
  - state typedef (IDLE/SHIFT/DONE);
  - default `CRC8_POLY` = 8'h07 and `CRC8_INIT` = 8'h00;
  - default frame-length constant.
- **Sub-module `crc_lfsr_step`:** purely combinational; maps (crc, bit) to crc_next and is parameterised by WIDTH and POLY. The top module holds the FSM, counter and output registers.

## Test plan
- **Reset:** hold `rst` for 2 cycles -> all outputs 0, `remainder` = INIT.
- **Good frame:** `start`, then bits 0x31 followed by 0x97 (16 bits, MSB first, `last` on bit 16) -> `crc_valid` = 1 for exactly one cycle, one cycle after the last bit; `remainder` = 0, `bit_count` = 16.
- **Single-bit error:** same frame with bit 3 flipped (0x39, 0x97) -> `crc_error` pulse, `crc_valid` stays 0, `remainder` != 0.
- **Short frame:** `start`, 4 zero bits, `last` on bit 4 -> `crc_error` despite `remainder` = 0.
- **Back-to-back with gaps:** good frame, then `start` in DONE, then a second good frame with random idle gaps in `bit_valid` -> two `crc_valid` pulses; the downstream counter advances by 2.
- **Abort:**
  - `rst` after 7 bits of a frame -> no pulse, IDLE.
  - Repeat, but with `start` mid-frame instead of `rst` -> only the restarted frame is judged.
